reg_wb_arbiter: RTL
===================

// Module: reg_wb_arbiter
// PURPOSE
//  Write-side master for the register file write port (w_write_reg/reg_des/reg_data/jal/jal_addr).
//  Merges in-order WB-stage results with out-of-order results from the long-latency unit (mul/div).
//  Long-latency results are queued in a FIFO and drained into idle write-port cycles.
//  A 32-entry busy scoreboard tells the decode stage which source registers are still pending.
// PARAMETERS
//  FIFO_DEPTH  2   long-latency result FIFO entries (power of two, >=2)
//  PTR_W       1   log2(FIFO_DEPTH)
// PORTS
//  clk            in   1   clock; all state updates on posedge
//  rst_n          in   1   asynchronous active-low reset
//  pipe_valid     in   1   WB-stage instruction writes a GPR this cycle
//  pipe_des       in   5   WB destination register
//  pipe_data      in   32  WB write data
//  pipe_jal       in   1   WB instruction is JAL (link write to r31)
//  pipe_jal_addr  in   32  link address for JAL
//  ml_issue       in   1   decode issues a long-latency op this cycle
//  ml_issue_des   in   5   its destination register
//  ml_valid       in   1   long-latency unit presents a result
//  ml_des         in   5   result destination
//  ml_data        in   32  result data
//  ml_ready       out  1   FIFO can accept (= !full); transfer when ml_valid&&ml_ready
//  rs, rt         in   5   decode-stage source registers (query)
//  rs_busy        out  1   rs has a pending long-latency write (combinational)
//  rt_busy        out  1   rt has a pending long-latency write (combinational)
//  w_write_reg    out  1   register-file write enable (registered)
//  reg_des        out  5   register-file write address (registered)
//  reg_data       out  32  register-file write data (registered)
//  jal            out  1   register-file link-write strobe (registered)
//  jal_addr       out  32  link address (registered)
//  waw_err        out  1   sticky: WB wrote a register marked busy
// BEHAVIOUR
//  Reset: all outputs 0, FIFO empty (ml_ready=1), scoreboard all clear, waw_err=0.
//  Latency: write-port outputs are one register stage after selection; reg file samples on negedge.
//  Per cycle, the port source is chosen in priority order:
//   1) pipe_valid && pipe_des!=0 -> {1,pipe_des,pipe_data}; WB is never stalled.
//   2) else FIFO non-empty -> pop head -> {1,head.des,head.data}.
//   3) else w_write_reg=0; reg_des/reg_data hold their last values.
//  pipe_valid with pipe_des==0: treated as no WB write; the FIFO may drain that cycle.
//  jal/jal_addr: registered copies of pipe_jal/pipe_jal_addr, independent of the selection above.
//  FIFO: push on ml_valid&&ml_ready, pop on a path-2 selection.
//   - Push and pop in the same cycle are both performed; count is unchanged.
//   - A push into an empty FIFO is not popped in the same cycle (no bypass).
//   - Pointers wrap modulo FIFO_DEPTH.
//   - ml_des==0 results are accepted but never written and never set busy.
//  Scoreboard busy[31:0]:
//   - set busy[ml_issue_des] on ml_issue (des!=0).
//   - clear on a FIFO pop of that des.
//   - set and clear of the same reg in one cycle -> set wins.
//  rs_busy = busy[rs] || FIFO holds an entry with des==rs (rt likewise).
//   - Reg 0 is never busy.
//   - A reg popped this cycle reads not-busy next cycle, when the write is visible.
//  WAW: pipe_valid && busy[pipe_des] (des!=0) sets waw_err; the write is still performed.
//   - waw_err is cleared only by reset.
//  Reset mid-operation: queued FIFO results are discarded and the scoreboard is cleared.
//   - The issuing pipeline is flushed by the same reset.
// TESTING
//  1. Reset, pipe_valid=1 des=5 data=0x1234 -> next cycle w_write_reg=1 reg_des=5 reg_data=0x1234.
//  2. Issue r9, then result r9=0xCAFE with no WB traffic:
//     -> rs=9 busy until written; w_write_reg r9=0xCAFE 2 cycles after ml_valid; rs_busy then 0.
//  3. Fill FIFO (2 results) under continuous pipe_valid:
//     -> ml_ready=0; first idle cycle drains the head; ml_ready=1 next cycle.
//  4. pipe_des=0 and pipe_jal=1 addr=0x40 with FIFO non-empty:
//     -> FIFO entry written; jal=1 jal_addr=0x40 same cycle.
//  5. ml_issue r3 in the same cycle r3 pops -> busy[3] stays 1.
//     Then WB write to r3 -> waw_err=1 and stays 1.
//  6. Assert rst_n=0 with FIFO full -> immediately ml_ready=1, busy clear, outputs 0.

Source files
------------

// File: rtl/reg_wb_arbiter.sv
// Register-file write-port arbiter: in-order WB results take priority, queued
// long-latency (mul/div) results drain into idle cycles; a busy scoreboard flags pending sources.
module reg_wb_arbiter #(
    parameter int FIFO_DEPTH = 2,
    parameter int PTR_W      = 1
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        pipe_valid,
    input  logic [4:0]  pipe_des,
    input  logic [31:0] pipe_data,
    input  logic        pipe_jal,
    input  logic [31:0] pipe_jal_addr,
    input  logic        ml_issue,
    input  logic [4:0]  ml_issue_des,
    input  logic        ml_valid,
    input  logic [4:0]  ml_des,
    input  logic [31:0] ml_data,
    output logic        ml_ready,
    input  logic [4:0]  rs,
    input  logic [4:0]  rt,
    output logic        rs_busy,
    output logic        rt_busy,
    output logic        w_write_reg,
    output logic [4:0]  reg_des,
    output logic [31:0] reg_data,
    output logic        jal,
    output logic [31:0] jal_addr,
    output logic        waw_err
);

    localparam logic [PTR_W:0] DEPTH_CNT = (PTR_W + 1)'(FIFO_DEPTH);

    logic [4:0]       fifo_des_reg  [FIFO_DEPTH];
    logic [31:0]      fifo_data_reg [FIFO_DEPTH];
    logic [PTR_W-1:0] wr_ptr_reg;
    logic [PTR_W-1:0] rd_ptr_reg;
    logic [PTR_W:0]   count_reg;
    logic [31:0]      busy_reg;
    logic [31:0]      busy_next;

    logic        pipe_wr;
    logic        fifo_empty;
    logic        push_en;
    logic        pop_en;
    logic [4:0]  head_des;
    logic [31:0] head_data;

    logic [FIFO_DEPTH-1:0] slot_live;
    logic [FIFO_DEPTH-1:0] rs_hit;
    logic [FIFO_DEPTH-1:0] rt_hit;

    assign pipe_wr    = pipe_valid && (pipe_des != 5'd0);
    assign fifo_empty = (count_reg == '0);
    assign ml_ready   = (count_reg != DEPTH_CNT);
    // Results for r0 complete the handshake but are dropped rather than queued.
    assign push_en    = ml_valid && ml_ready && (ml_des != 5'd0);
    // count_reg excludes this cycle's push, so a fresh entry is never popped at once.
    assign pop_en     = !pipe_wr && !fifo_empty;
    assign head_des   = fifo_des_reg[rd_ptr_reg];
    assign head_data  = fifo_data_reg[rd_ptr_reg];

    always_ff @(posedge clk) begin
        if (push_en) begin
            fifo_des_reg[wr_ptr_reg]  <= ml_des;
            fifo_data_reg[wr_ptr_reg] <= ml_data;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_reg <= '0;
            rd_ptr_reg <= '0;
            count_reg  <= '0;
        end else begin
            if (push_en) wr_ptr_reg <= wr_ptr_reg + 1'b1;
            if (pop_en)  rd_ptr_reg <= rd_ptr_reg + 1'b1;
            case ({push_en, pop_en})
                2'b10:   count_reg <= count_reg + 1'b1;
                2'b01:   count_reg <= count_reg - 1'b1;
                default: count_reg <= count_reg;
            endcase
        end
    end

    // A slot is live when its distance from the read pointer is below the fill count.
    for (genvar gi = 0; gi < FIFO_DEPTH; gi++) begin : g_slot
        logic [PTR_W-1:0] slot_age;
        assign slot_age      = PTR_W'(gi) - rd_ptr_reg;
        assign slot_live[gi] = ({1'b0, slot_age} < count_reg);
        assign rs_hit[gi]    = slot_live[gi] && (fifo_des_reg[gi] == rs);
        assign rt_hit[gi]    = slot_live[gi] && (fifo_des_reg[gi] == rt);
    end

    assign rs_busy = (rs != 5'd0) && (busy_reg[rs] || (|rs_hit));
    assign rt_busy = (rt != 5'd0) && (busy_reg[rt] || (|rt_hit));

    // Clear first, then set, so a same-cycle issue of the popped register stays busy.
    always_comb begin
        busy_next = busy_reg;
        if (pop_en) begin
            busy_next[head_des] = 1'b0;
        end
        if (ml_issue && (ml_issue_des != 5'd0)) begin
            busy_next[ml_issue_des] = 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            busy_reg <= '0;
        end else begin
            busy_reg <= busy_next;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            w_write_reg <= 1'b0;
            reg_des     <= '0;
            reg_data    <= '0;
            jal         <= 1'b0;
            jal_addr    <= '0;
            waw_err     <= 1'b0;
        end else begin
            jal      <= pipe_jal;
            jal_addr <= pipe_jal_addr;
            if (pipe_wr) begin
                w_write_reg <= 1'b1;
                reg_des     <= pipe_des;
                reg_data    <= pipe_data;
            end else if (pop_en) begin
                w_write_reg <= 1'b1;
                reg_des     <= head_des;
                reg_data    <= head_data;
            end else begin
                w_write_reg <= 1'b0;
            end
            if (pipe_wr && busy_reg[pipe_des]) begin
                waw_err <= 1'b1;
            end
        end
    end

endmodule
